ifetch_unit: RTL and testbench

Instruction fetch stage of the kanade32 core. It holds the fetch PC and issues word reads to instruction memory over a valid/ready request channel. It queues the in-order responses together with their PCs and hands instruction words to the decode stage over a valid/ready handshake. Branch, jump and `jr` redirects from the execute stage flush the queue and discard stale in-flight responses.

---
 rtl/ifetch_pkg.sv | 33 +++
 rtl/ifetch_fifo.sv | 75 +++++++
 rtl/ifetch_unit.sv | 140 ++++++++++++++
 tb/tb_ifetch_unit.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ifetch_pkg
//  Description : Shared types, default parameters and helpers for the
//                kanade32 instruction fetch stage.
//                - IFETCH_RESET_PC / IFETCH_DEPTH : default parameter values
//                - fetch_state_t                  : fetch FSM state encoding
//                - fetch_entry_t                  : prefetch queue entry {pc, word}
//                - word_align()                   : clears address bits [1:0]
//  Revision    : 1.0 - initial release
// ============================================================================
package ifetch_pkg;

    localparam logic [31:0] IFETCH_RESET_PC = 32'h0000_0000;
    localparam int          IFETCH_DEPTH    = 4;

    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_START = 2'd1,
        ST_RUN   = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] word;
    } fetch_entry_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ifetch_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : ifetch_fifo
//  Description : Synchronous prefetch queue, 64-bit entries ({pc, word}).
//                The head entry is read straight from the storage registers
//                so the consumer sees it with no extra latency.
//  Ports       : clk, rst_n      - clock, synchronous active-low reset
//                push, push_data - write one entry
//                pop             - consume the head entry (ignored if empty)
//                flush           - discard all entries (wins over push/pop)
//                head_valid      - queue not empty
//                head_data       - head entry
//                count           - occupancy, 0..DEPTH
//  Revision    : 1.0 - initial release
// ============================================================================
module ifetch_fifo #(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [63:0]   push_data,
    input  logic          pop,
    input  logic          flush,
    output logic          head_valid,
    output logic [63:0]   head_data,
    output logic [CW-1:0] count
);

    localparam int            c_AW   = $clog2(DEPTH);
    localparam logic [CW-1:0] c_FULL = CW'(DEPTH);

    logic [63:0]     r_mem [DEPTH];
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_AW-1:0] r_wr_ptr;
    logic [CW-1:0]   r_count;

    logic w_pop;
    logic w_push;

    assign w_pop  = pop & (r_count != '0);
    // A push into a full queue is only legal when the head leaves this cycle.
    assign w_push = push & ((r_count != c_FULL) | w_pop);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= push_data;
                r_wr_ptr        <= r_wr_ptr + c_AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_AW'(1);
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    assign head_valid = (r_count != '0);
    assign head_data  = r_mem[r_rd_ptr];
    assign count      = r_count;

endmodule
`default_nettype wire

// File: rtl/ifetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : ifetch_unit
//  Description : kanade32 instruction fetch stage. Holds the fetch PC,
//                issues word reads under a credit limit of DEPTH, tags the
//                in-order responses with their PCs in a prefetch queue and
//                hands them to decode. Redirects flush the queue and mark all
//                in-flight responses for discard.
//  Ports       : clk, rst_n                      - clock, sync active-low reset
//                imem_req_valid/ready/addr       - fetch request channel
//                imem_rsp_valid/data             - in-order read responses
//                ins_valid/ready                 - decode handshake
//                ins_word, ins_pc, ins_pc_plus4  - delivered instruction
//                redirect, redirect_pc           - one-cycle fetch restart
//  Revision    : 1.0 - initial release
// ============================================================================
module ifetch_unit
    import ifetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = IFETCH_RESET_PC,
    parameter int          DEPTH    = IFETCH_DEPTH
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        ins_valid,
    input  logic        ins_ready,
    output logic [31:0] ins_word,
    output logic [31:0] ins_pc,
    output logic [31:0] ins_pc_plus4,
    input  logic        redirect,
    input  logic [31:0] redirect_pc
);

    localparam int              c_CW    = $clog2(DEPTH) + 1;
    localparam int              c_IW    = c_CW + 1;
    localparam logic [c_IW-1:0] c_DEPTH = c_IW'(DEPTH);

    fetch_state_t    r_state;
    logic [31:0]     r_fetch_pc;
    logic [31:0]     r_rsp_pc;
    logic [c_CW-1:0] r_outstanding;
    logic [c_CW-1:0] r_drop;

    logic [c_CW-1:0] w_count;
    logic [c_IW-1:0] w_inflight;
    logic            w_req_fire;
    logic            w_rsp_keep;
    logic            w_rsp_drop;
    logic            w_push;
    logic            w_pop;
    logic            w_head_valid;
    logic [63:0]     w_head_data;
    fetch_entry_t    w_push_entry;
    fetch_entry_t    w_head_entry;
    logic [31:0]     w_target;

    // Every slot that is queued, expected or pending discard holds a credit.
    assign w_inflight     = {1'b0, w_count} + {1'b0, r_outstanding} + {1'b0, r_drop};
    assign imem_req_valid = (r_state == ST_RUN) && (w_inflight < c_DEPTH);
    assign imem_req_addr  = r_fetch_pc;

    assign w_req_fire = imem_req_valid & imem_req_ready;
    assign w_rsp_drop = imem_rsp_valid & (r_drop != '0);
    assign w_rsp_keep = imem_rsp_valid & (r_drop == '0);
    // A response landing in the redirect cycle is stale by definition.
    assign w_push     = w_rsp_keep & ~redirect;
    assign w_pop      = ins_valid & ins_ready;
    assign w_target   = word_align(redirect_pc);

    assign w_push_entry.pc   = r_rsp_pc;
    assign w_push_entry.word = imem_rsp_data;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= ST_RESET;
            r_fetch_pc    <= RESET_PC;
            r_rsp_pc      <= RESET_PC;
            r_outstanding <= '0;
            r_drop        <= '0;
        end else begin
            case (r_state)
                ST_RESET: r_state <= ST_START;
                ST_START: r_state <= ST_RUN;
                default:  r_state <= ST_RUN;
            endcase

            if (redirect) begin
                r_fetch_pc    <= w_target;
                r_rsp_pc      <= w_target;
                r_outstanding <= '0;
                // Retire this cycle's response against the old counters, then
                // everything still expected (including a same-cycle accept)
                // becomes discard debt.
                r_drop        <= (r_drop - c_CW'(w_rsp_drop))
                               + (r_outstanding - c_CW'(w_rsp_keep))
                               + c_CW'(w_req_fire);
            end else begin
                if (w_req_fire) begin
                    r_fetch_pc <= r_fetch_pc + 32'd4;
                end
                if (w_push) begin
                    r_rsp_pc <= r_rsp_pc + 32'd4;
                end
                r_outstanding <= r_outstanding + c_CW'(w_req_fire) - c_CW'(w_rsp_keep);
                r_drop        <= r_drop - c_CW'(w_rsp_drop);
            end
        end
    end

    ifetch_fifo #(
        .DEPTH (DEPTH),
        .CW    (c_CW)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (w_push),
        .push_data  (w_push_entry),
        .pop        (w_pop),
        .flush      (redirect),
        .head_valid (w_head_valid),
        .head_data  (w_head_data),
        .count      (w_count)
    );

    assign w_head_entry = w_head_data;

    // Outputs read as zero whenever nothing is presented, so reset and
    // flushed states show a clean bus.
    assign ins_valid    = w_head_valid;
    assign ins_word     = w_head_valid ? w_head_entry.word : '0;
    assign ins_pc       = w_head_valid ? w_head_entry.pc : '0;
    assign ins_pc_plus4 = w_head_valid ? (w_head_entry.pc + 32'd4) : '0;

endmodule
`default_nettype wire

// File: tb/tb_ifetch_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_ifetch_unit
//  Description : Self-checking bench for ifetch_unit. Models instruction
//                memory with configurable latency, keeps a program-order
//                expectation queue and compares every delivered instruction.
//                A second instance with RESET_PC = 0xFFFF_FFF8 covers wrap.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ifetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        ins_valid, ins_ready;
    logic [31:0] ins_word, ins_pc, ins_pc_plus4;
    logic        redirect;
    logic [31:0] redirect_pc;

    logic        wr_req_valid;
    logic [31:0] wr_req_addr;
    logic        wr_rsp_valid = 1'b0;
    logic [31:0] wr_rsp_data  = 32'h0;
    logic        wr_ins_valid;
    logic [31:0] wr_ins_word, wr_ins_pc, wr_ins_pc_plus4;

    always #5 clk = ~clk;

    ifetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .ins_valid(ins_valid), .ins_ready(ins_ready),
        .ins_word(ins_word), .ins_pc(ins_pc), .ins_pc_plus4(ins_pc_plus4),
        .redirect(redirect), .redirect_pc(redirect_pc)
    );

    ifetch_unit #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(4)) dut_wrap (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(wr_req_valid), .imem_req_ready(1'b1),
        .imem_req_addr(wr_req_addr),
        .imem_rsp_valid(wr_rsp_valid), .imem_rsp_data(wr_rsp_data),
        .ins_valid(wr_ins_valid), .ins_ready(1'b1),
        .ins_word(wr_ins_word), .ins_pc(wr_ins_pc), .ins_pc_plus4(wr_ins_pc_plus4),
        .redirect(1'b0), .redirect_pc(32'h0)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory image: deterministic scramble of the address.
    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct { logic [31:0] addr; int due; } pend_t;
    pend_t       pend[$];
    logic [31:0] exp_q[$];
    logic [31:0] model_pc = 32'h0;
    logic [31:0] last_pop_pc = 32'h0;
    int          last_due = 0;
    int          lat_min = 1, lat_max = 1;
    int          req_pct = 100, rdy_pct = 100;
    int          n_fire = 0, n_pop = 0;

    // Request tracker: checks addresses against the program-order model,
    // schedules memory responses and pushes expected deliveries.
    always begin : tracker
        int d;
        @(negedge clk);
        #1;
        if (!rst_n) begin
            exp_q.delete();
            pend.delete();
            model_pc = 32'h0;
            last_due = 0;
        end else begin
            if (imem_req_valid && imem_req_ready) begin
                check("req_addr", imem_req_addr, model_pc);
                d = cyc + $urandom_range(lat_max, lat_min);
                if (d <= last_due) d = last_due + 1;
                last_due = d;
                pend.push_back('{imem_req_addr, d});
                n_fire++;
                if (!redirect) exp_q.push_back(model_pc);
                model_pc = model_pc + 32'd4;
            end
            if (redirect) begin
                exp_q.delete();
                model_pc = redirect_pc & ~32'h3;
            end
        end
    end

    // Monitor: every decode handshake must match the head of the expectation.
    always begin : monitor
        logic [31:0] e;
        @(negedge clk);
        if (rst_n && ins_valid && ins_ready) begin
            n_pop++;
            last_pop_pc = ins_pc;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL ins_unexpected: got pc=%h expected no delivery (cycle %0d)", ins_pc, cyc);
            end else begin
                e = exp_q.pop_front();
                check("ins_pc", ins_pc, e);
                check("ins_word", ins_word, memf(e));
                check("ins_pc_plus4", ins_pc_plus4, e + 32'd4);
            end
        end
    end

    // Wrap instance: fixed-latency memory and checks on its first transfers.
    logic        wr_fire = 1'b0;
    logic [31:0] wr_fire_addr = 32'h0;
    int          wr_nreq = 0, wr_npop = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            wr_nreq = 0;
            wr_npop = 0;
            wr_fire = 1'b0;
        end else begin
            if (wr_req_valid) begin
                if (wr_nreq < 3) check("wrap_req_addr", wr_req_addr, 32'hFFFF_FFF8 + 32'(4 * wr_nreq));
                wr_nreq++;
            end
            if (wr_ins_valid) begin
                if (wr_npop < 2) begin
                    check("wrap_ins_pc", wr_ins_pc, 32'hFFFF_FFF8 + 32'(4 * wr_npop));
                    check("wrap_ins_word", wr_ins_word, memf(32'hFFFF_FFF8 + 32'(4 * wr_npop)));
                    check("wrap_pc_plus4", wr_ins_pc_plus4, 32'hFFFF_FFFC + 32'(4 * wr_npop));
                end
                wr_npop++;
            end
            wr_fire      = wr_req_valid;
            wr_fire_addr = wr_req_addr;
        end
    end

    always @(posedge clk) begin
        #1;
        wr_rsp_valid = rst_n && wr_fire;
        wr_rsp_data  = memf(wr_fire_addr);
    end

    task automatic tick();
        @(posedge clk);
        #1;
        redirect = 1'b0;
        if (!rst_n) begin
            imem_req_ready = 1'($urandom);
            ins_ready      = 1'($urandom);
            imem_rsp_valid = 1'($urandom);
            imem_rsp_data  = $urandom;
            redirect       = 1'($urandom);
            redirect_pc    = $urandom;
        end else begin
            imem_req_ready = ($urandom_range(99, 0) < req_pct);
            ins_ready      = ($urandom_range(99, 0) < rdy_pct);
            if (pend.size() > 0 && pend[0].due <= cyc) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = memf(pend[0].addr);
                void'(pend.pop_front());
            end else begin
                imem_rsp_valid = 1'b0;
                imem_rsp_data  = $urandom;
            end
        end
    endtask

    // Holds reset for three cycles of random inputs, checks the reset state,
    // then releases reset with quiet inputs.
    task automatic do_reset();
        tick();
        rst_n = 1'b0;
        repeat (3) tick();
        #3;
        check("rst_req_valid", imem_req_valid, 0);
        check("rst_req_addr", imem_req_addr, 32'h0);
        check("rst_ins_valid", ins_valid, 0);
        check("rst_ins_word", ins_word, 0);
        check("rst_ins_pc", ins_pc, 0);
        check("rst_ins_pc_plus4", ins_pc_plus4, 0);
        check("rst_wrap_addr", wr_req_addr, 32'hFFFF_FFF8);
        rst_n          = 1'b1;
        redirect       = 1'b0;
        imem_rsp_valid = 1'b0;
    endtask

    int  p0, f0;
    logic found;

    initial begin
        rst_n = 1'b0; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
        ins_ready = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;

        // Reset release and streaming at k=1.
        lat_min = 1; lat_max = 1; req_pct = 100; rdy_pct = 100;
        do_reset();
        tick(); #3;
        check("start_no_req", imem_req_valid, 0);
        tick(); #3;
        check("first_req_valid", imem_req_valid, 1);
        check("first_req_addr", imem_req_addr, 32'h0);
        tick(); tick();
        p0 = n_pop;
        repeat (16) tick();
        check("stream_rate", 32'(n_pop - p0), 32'd16);

        // Backpressure: decode stalled for a long time.
        rdy_pct = 0;
        do_reset();
        f0 = n_fire;
        repeat (22) tick();
        #3;
        check("bp_accepted", 32'(n_fire - f0), 32'd4);
        check("bp_hold_valid", ins_valid, 1);
        check("bp_hold_pc", ins_pc, 32'h0);
        check("bp_hold_word", ins_word, memf(32'h0));
        rdy_pct = 100;
        p0 = n_pop;
        repeat (10) tick();
        check("bp_drain", 32'(n_pop - p0 >= 6), 1);

        // Redirect with two responses in flight at k=3.
        lat_min = 3; lat_max = 3; req_pct = 100; rdy_pct = 100;
        do_reset();
        tick(); tick(); tick();
        req_pct = 0;
        tick();
        redirect = 1'b1; redirect_pc = 32'h0000_0103;
        req_pct = 100;
        tick(); #3;
        check("redir_ins_valid_off", ins_valid, 0);
        check("redir_req_addr", imem_req_addr, 32'h0000_0100);
        check("redir_req_valid", imem_req_valid, 1);
        p0 = n_pop;
        repeat (15) tick();
        check("redir_progress", 32'(n_pop - p0 >= 5), 1);

        // Redirect in the same cycle as the pop of 0x20.
        lat_min = 1; lat_max = 1;
        do_reset();
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            tick();
            found = ins_valid && (ins_pc == 32'h20);
        end
        check("wait_pc20", found, 1);
        redirect = 1'b1; redirect_pc = 32'h0000_0200; ins_ready = 1'b1;
        tick(); #3;
        check("pop_redir_consumed", last_pop_pc, 32'h20);
        check("pop_redir_valid_off", ins_valid, 0);
        p0 = n_pop;
        repeat (10) tick();
        check("pop_redir_progress", 32'(n_pop - p0 >= 5), 1);

        // Randomized traffic with random latency, stalls and redirects.
        lat_min = 1; lat_max = 4; req_pct = 70; rdy_pct = 60;
        do_reset();
        p0 = n_pop;
        repeat (400) begin
            tick();
            if ($urandom_range(19, 0) == 0) begin
                redirect    = 1'b1;
                redirect_pc = $urandom;
            end
        end
        check("rand_progress", 32'(n_pop - p0 >= 20), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
